// File: rtl/icode_count_dumper.sv
// rtl/icode_count_dumper.sv - scans the icode count memory, streams (icode, count) pairs, keeps total/max summary
module icode_count_dumper #(
  parameter int ICODESIZE = 4,
  parameter int COUNTBITS = 4,
  parameter int SUMBITS   = ICODESIZE + COUNTBITS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 clear_on_read,
  output logic [ICODESIZE-1:0] mem_addr,
  input  logic [COUNTBITS-1:0] mem_rd_data,
  output logic                 mem_we,
  output logic [COUNTBITS-1:0] mem_wr_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ICODESIZE-1:0] out_icode,
  output logic [COUNTBITS-1:0] out_count,
  output logic                 busy,
  output logic                 done,
  output logic [SUMBITS-1:0]   total_count,
  output logic [ICODESIZE-1:0] max_icode,
  output logic [COUNTBITS-1:0] max_count
);

  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, SEND, FINISH} state_t;

  state_t               state, next_state;
  logic [ICODESIZE-1:0] idx;
  logic                 clr;
  logic [SUMBITS-1:0]   run_sum;
  logic [COUNTBITS-1:0] run_max;
  logic [ICODESIZE-1:0] run_max_icode;
  logic                 last_idx;

  assign last_idx    = &idx;
  assign mem_addr    = idx;
  assign mem_wr_data = '0;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    out_valid  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    mem_we     = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) next_state = ISSUE;
      end
      ISSUE:   next_state = CAPTURE;
      CAPTURE: begin
        mem_we     = clr;
        next_state = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        if (out_ready) next_state = last_idx ? FINISH : ISSUE;
      end
      FINISH: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        busy       = 1'b0;
        next_state = IDLE;
      end
    endcase
  end

  // Strict compare keeps the lowest icode on ties.
  always_ff @(posedge clock) begin
    if (reset) begin
      idx           <= '0;
      clr           <= 1'b0;
      run_sum       <= '0;
      run_max       <= '0;
      run_max_icode <= '0;
      out_icode     <= '0;
      out_count     <= '0;
      total_count   <= '0;
      max_icode     <= '0;
      max_count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            clr           <= clear_on_read;
            idx           <= '0;
            run_sum       <= '0;
            run_max       <= '0;
            run_max_icode <= '0;
          end
        end
        CAPTURE: begin
          out_count <= mem_rd_data;
          out_icode <= idx;
          run_sum   <= run_sum + {{(SUMBITS-COUNTBITS){1'b0}}, mem_rd_data};
          if (mem_rd_data > run_max) begin
            run_max       <= mem_rd_data;
            run_max_icode <= idx;
          end
        end
        SEND: begin
          if (out_ready && !last_idx) idx <= idx + 1'b1;
        end
        FINISH: begin
          total_count <= run_sum;
          max_icode   <= run_max_icode;
          max_count   <= run_max;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_icode_count_dumper.sv
// tb/tb_icode_count_dumper.sv - directed self-checking bench for icode_count_dumper
module tb_icode_count_dumper;

  logic       clock = 1'b0;
  logic       reset, start, clear_on_read, out_ready;
  logic [3:0] mem_addr, mem_rd_data, mem_wr_data, out_icode, out_count;
  logic       mem_we, out_valid, busy, done;
  logic [7:0] total_count;
  logic [3:0] max_icode, max_count;

  logic [3:0] mem      [16];
  logic [3:0] init_mem [16];
  logic [3:0] exp_cnt  [16];
  logic       load;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  icode_count_dumper #(.ICODESIZE(4), .COUNTBITS(4), .SUMBITS(8)) dut (
    .clock(clock), .reset(reset), .start(start), .clear_on_read(clear_on_read),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .mem_we(mem_we),
    .mem_wr_data(mem_wr_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_icode(out_icode), .out_count(out_count), .busy(busy), .done(done),
    .total_count(total_count), .max_icode(max_icode), .max_count(max_count)
  );

  always @(posedge clock) begin
    if (load) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_mem[i];
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wr_data;
    end
    mem_rd_data <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load_mem();
    @(negedge clock); load = 1'b1;
    @(negedge clock); load = 1'b0;
  endtask

  task automatic run_scan(input bit clr, input bit bp, input bit glitch,
                          input int exp_total, input int exp_maxi, input int exp_maxc);
    int         n = 0;
    int         cyc = 0;
    int         first = -1;
    int         donec = -1;
    int         bad = 0;
    bit         pend = 0;
    logic [3:0] pi = '0, pc = '0;
    logic [3:0] gi [16];
    logic [3:0] gc [16];
    logic [3:0] pat = 4'b1001;
    @(negedge clock);
    start = 1'b1; clear_on_read = clr; out_ready = !bp;
    @(negedge clock);
    start = 1'b0; clear_on_read = 1'b0;
    while (cyc < 400 && donec < 0) begin
      if (busy && first < 0) first = cyc;
      if (done) donec = cyc;
      if (pend) begin
        check("hold_valid", out_valid, 1);
        check("hold_icode", out_icode, pi);
        check("hold_count", out_count, pc);
      end
      if (glitch && first >= 0 && cyc == first + 10) begin
        start = 1'b1; clear_on_read = 1'b1;
      end else begin
        start = 1'b0; clear_on_read = 1'b0;
      end
      if (bp) out_ready = pat[cyc % 4];
      pend = out_valid && !out_ready;
      pi = out_icode; pc = out_count;
      if (out_valid && out_ready) begin
        if (n < 16) begin gi[n] = out_icode; gc[n] = out_count; end
        n++;
      end
      @(negedge clock);
      cyc++;
    end
    start = 1'b0; clear_on_read = 1'b0; out_ready = 1'b1;
    check("done_seen", donec >= 0, 1);
    check("pair_count", n, 16);
    for (int i = 0; i < 16 && i < n; i++) begin
      check($sformatf("icode[%0d]", i), gi[i], i);
      check($sformatf("count[%0d]", i), gc[i], exp_cnt[i]);
    end
    if (!bp && !glitch) check("latency", donec - first + 1, 49);
    check("done_pulse", done, 0);
    check("busy_after", busy, 0);
    check("total_count", total_count, exp_total);
    check("max_icode", max_icode, exp_maxi);
    check("max_count", max_count, exp_maxc);
    for (int i = 0; i < 16; i++)
      if (mem[i] !== (clr ? 4'd0 : exp_cnt[i])) bad++;
    check("mem_after", bad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int found, wes, dones, bad;
    reset = 1'b1; start = 1'b0; clear_on_read = 1'b0; out_ready = 1'b0; load = 1'b0;
    for (int i = 0; i < 16; i++) init_mem[i] = 4'(i);
    repeat (2) @(negedge clock);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_icode", out_icode, 0);
    check("rst_out_count", out_count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_total", total_count, 0);
    check("rst_max_icode", max_icode, 0);
    check("rst_max_count", max_count, 0);
    reset = 1'b0;

    load_mem();
    for (int i = 0; i < 16; i++) exp_cnt[i] = 4'(i);
    run_scan(0, 0, 0, 120, 15, 15);
    run_scan(0, 1, 0, 120, 15, 15);
    run_scan(0, 0, 1, 120, 15, 15);

    // Abort with clearing enabled while icode 5 is being presented.
    @(negedge clock);
    start = 1'b1; clear_on_read = 1'b1; out_ready = 1'b0;
    @(negedge clock);
    start = 1'b0; clear_on_read = 1'b0;
    found = 0;
    for (int c = 0; c < 100 && found == 0; c++) begin
      if (out_valid && out_icode == 4'd5) found = 1;
      else begin
        out_ready = out_valid;
        @(negedge clock);
        out_ready = 1'b0;
      end
    end
    check("mid_found_5", found, 1);
    reset = 1'b1;
    @(negedge clock);
    check("mid_out_valid", out_valid, 0);
    check("mid_busy", busy, 0);
    check("mid_total", total_count, 0);
    check("mid_max_icode", max_icode, 0);
    check("mid_max_count", max_count, 0);
    reset = 1'b0; out_ready = 1'b1;
    wes = 0; dones = 0;
    repeat (60) begin
      @(negedge clock);
      if (mem_we) wes++;
      if (done) dones++;
    end
    check("mid_no_we", wes, 0);
    check("mid_no_done", dones, 0);
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (mem[i] !== ((i <= 5) ? 4'd0 : 4'(i))) bad++;
    check("mid_mem", bad, 0);

    for (int i = 0; i < 16; i++) begin init_mem[i] = 4'd7; exp_cnt[i] = 4'd7; end
    load_mem();
    run_scan(1, 0, 0, 112, 0, 7);
    for (int i = 0; i < 16; i++) exp_cnt[i] = 4'd0;
    run_scan(0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
